// File: rtl/csr_wbmaster_pkg.sv
// Shared definitions for the CSR-driven Wishbone initiator.
// Register indices, CTRL/STATUS bit positions and FSM state encoding.
// Imported by csr_wbmaster and its testbench.
package csr_wbmaster_pkg;

   // Register indices (csr_a[2:0])
   localparam logic [2:0] REG_ADDR    = 3'd0;
   localparam logic [2:0] REG_WDATA   = 3'd1;
   localparam logic [2:0] REG_RDATA   = 3'd2;
   localparam logic [2:0] REG_SUM     = 3'd3;
   localparam logic [2:0] REG_COUNT   = 3'd4;
   localparam logic [2:0] REG_CTRL    = 3'd5;
   localparam logic [2:0] REG_STATUS  = 3'd6;
   localparam logic [2:0] REG_TIMEOUT = 3'd7;

   // CTRL bit positions
   localparam int CTRL_START   = 0;
   localparam int CTRL_WE      = 1;
   localparam int CTRL_ABORT   = 2;
   localparam int CTRL_SEL_LSB = 4;

   // STATUS bit positions
   localparam int STAT_BUSY    = 0;
   localparam int STAT_DONE    = 1;
   localparam int STAT_TIMEOUT = 2;
   localparam int STAT_ABORTED = 3;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      GAP  = 2'd2
   } state_e;

endpackage

// File: rtl/csr_wbmaster.sv
// CSR-programmed Wishbone classic-cycle initiator (single or sequential beats).
// Latency: CSR read 1 cycle; bus cycle starts the cycle after the start write.
// Backpressure: each beat holds cyc/stb until ack, timeout or abort.
module csr_wbmaster
   import csr_wbmaster_pkg::*;
#(
   parameter logic [3:0]  csr_addr      = 4'h9,
   parameter logic [15:0] TIMEOUT_RESET = 16'd1024
) (
   input  logic        sys_clk,
   input  logic        sys_rst,
   input  logic [13:0] csr_a,
   input  logic        csr_we,
   input  logic [31:0] csr_di,
   output logic [31:0] csr_do,
   output logic [31:0] wb_adr_o,
   output logic [31:0] wb_dat_o,
   input  logic [31:0] wb_dat_i,
   output logic [3:0]  wb_sel_o,
   output logic [2:0]  wb_cti_o,
   output logic        wb_we_o,
   output logic        wb_cyc_o,
   output logic        wb_stb_o,
   input  logic        wb_ack_i,
   output logic        irq
);

   state_e      state_q, state_d;

   logic [31:0] addr_q, addr_d;
   logic [31:0] wdata_q, wdata_d;
   logic [31:0] rdata_q, rdata_d;
   logic [31:0] sum_q, sum_d;
   logic [15:0] count_q, count_d;
   logic [15:0] timeout_q, timeout_d;
   logic        we_q, we_d;
   logic [3:0]  sel_q, sel_d;
   logic        done_q, done_d;
   logic        tout_q, tout_d;
   logic        aborted_q, aborted_d;
   logic [15:0] rem_q, rem_d;
   logic [31:0] cur_adr_q, cur_adr_d;
   logic [31:0] cmd_dat_q, cmd_dat_d;
   logic [15:0] tcnt_q, tcnt_d;
   logic [31:0] csr_do_q, csr_do_d;

   logic [2:0]  reg_idx;
   logic        csr_sel, csr_wr, ctrl_wr, busy;
   logic        start_cmd, abort_cmd, ack_ok, last_beat, to_hit, done_set;
   logic        unused_csr_bits;

   assign reg_idx         = csr_a[2:0];
   assign unused_csr_bits = ^csr_a[9:3];
   assign csr_sel         = (csr_a[13:10] == csr_addr);
   assign csr_wr          = csr_sel && csr_we;
   assign ctrl_wr         = csr_wr && (reg_idx == REG_CTRL);
   assign busy            = (state_q != IDLE);

   // Abort beats start when both bits arrive in one write; either is a no-op in the wrong state.
   assign abort_cmd = ctrl_wr && csr_di[CTRL_ABORT] && busy;
   assign start_cmd = ctrl_wr && csr_di[CTRL_START] && !csr_di[CTRL_ABORT] && !busy;
   assign ack_ok    = (state_q == REQ) && wb_ack_i;
   assign last_beat = ack_ok && (rem_q == 16'd1);
   // tcnt_q counts completed REQ cycles, so the beat dies after exactly TIMEOUT cycles.
   assign to_hit    = (state_q == REQ) && !wb_ack_i && (timeout_q != 16'd0)
                      && ((tcnt_q + 16'd1) == timeout_q);
   // Done is raised on the edge that enters GAP with nothing left to do.
   assign done_set  = !abort_cmd && ((start_cmd && (count_q == 16'd0)) || last_beat);

   // FSM state register
   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) state_q <= IDLE;
      else         state_q <= state_d;
   end

   // FSM next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: if (start_cmd) state_d = (count_q != 16'd0) ? REQ : GAP;
         REQ: begin
            if (abort_cmd)     state_d = IDLE;
            else if (wb_ack_i) state_d = GAP;
            else if (to_hit)   state_d = IDLE;
         end
         GAP: begin
            if (abort_cmd || (rem_q == 16'd0)) state_d = IDLE;
            else                               state_d = REQ;
         end
         default: state_d = IDLE;
      endcase
   end

   // FSM outputs: the bus is requested only while in REQ
   always_comb begin
      wb_cyc_o = (state_q == REQ);
      wb_stb_o = (state_q == REQ);
   end

   // Register file, command latching and beat datapath
   always_comb begin
      addr_d    = addr_q;
      wdata_d   = wdata_q;
      rdata_d   = rdata_q;
      sum_d     = sum_q;
      count_d   = count_q;
      timeout_d = timeout_q;
      we_d      = we_q;
      sel_d     = sel_q;
      done_d    = done_q;
      tout_d    = tout_q;
      aborted_d = aborted_q;
      rem_d     = rem_q;
      cur_adr_d = cur_adr_q;
      cmd_dat_d = cmd_dat_q;
      tcnt_d    = (state_q == REQ) ? (tcnt_q + 16'd1) : 16'd0;

      if (csr_wr) begin
         case (reg_idx)
            REG_ADDR:    addr_d    = csr_di;
            REG_WDATA:   wdata_d   = csr_di;
            REG_COUNT:   count_d   = csr_di[15:0];
            REG_TIMEOUT: timeout_d = csr_di[15:0];
            REG_CTRL: begin
               // we/sel drive the bus, so they only change between commands
               if (!busy) begin
                  we_d  = csr_di[CTRL_WE];
                  sel_d = csr_di[CTRL_SEL_LSB +: 4];
               end
            end
            REG_STATUS: begin
               done_d    = done_q    & ~csr_di[STAT_DONE];
               tout_d    = tout_q    & ~csr_di[STAT_TIMEOUT];
               aborted_d = aborted_q & ~csr_di[STAT_ABORTED];
            end
            default: ;
         endcase
      end

      if (start_cmd) begin
         rem_d     = count_q;
         cur_adr_d = {addr_q[31:2], 2'b00};
         cmd_dat_d = wdata_q;
         sum_d     = 32'd0;
         done_d    = 1'b0;
         tout_d    = 1'b0;
         aborted_d = 1'b0;
      end

      // An ack coincident with an abort still delivers its data
      if (ack_ok) begin
         if (!we_q) begin
            rdata_d = wb_dat_i;
            sum_d   = sum_q + wb_dat_i;
         end
         rem_d     = rem_q - 16'd1;
         cur_adr_d = cur_adr_q + 32'd4;
      end

      if (done_set)  done_d    = 1'b1;
      if (to_hit && !abort_cmd) tout_d = 1'b1;
      if (abort_cmd) aborted_d = 1'b1;
   end

   // CSR read mux, registered; silent when another page is addressed
   always_comb begin
      csr_do_d = 32'd0;
      if (csr_sel) begin
         case (reg_idx)
            REG_ADDR:    csr_do_d = addr_q;
            REG_WDATA:   csr_do_d = wdata_q;
            REG_RDATA:   csr_do_d = rdata_q;
            REG_SUM:     csr_do_d = sum_q;
            REG_COUNT:   csr_do_d = {16'd0, count_q};
            REG_CTRL:    csr_do_d = {24'd0, sel_q, 2'b00, we_q, 1'b0};
            REG_STATUS:  csr_do_d = {28'd0, aborted_q, tout_q, done_q, busy};
            REG_TIMEOUT: csr_do_d = {16'd0, timeout_q};
            default:     csr_do_d = 32'd0;
         endcase
      end
   end

   // State for registers and datapath
   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) begin
         addr_q    <= 32'd0;
         wdata_q   <= 32'd0;
         rdata_q   <= 32'd0;
         sum_q     <= 32'd0;
         count_q   <= 16'd0;
         timeout_q <= TIMEOUT_RESET;
         we_q      <= 1'b0;
         sel_q     <= 4'd0;
         done_q    <= 1'b0;
         tout_q    <= 1'b0;
         aborted_q <= 1'b0;
         rem_q     <= 16'd0;
         cur_adr_q <= 32'd0;
         cmd_dat_q <= 32'd0;
         tcnt_q    <= 16'd0;
         csr_do_q  <= 32'd0;
      end else begin
         addr_q    <= addr_d;
         wdata_q   <= wdata_d;
         rdata_q   <= rdata_d;
         sum_q     <= sum_d;
         count_q   <= count_d;
         timeout_q <= timeout_d;
         we_q      <= we_d;
         sel_q     <= sel_d;
         done_q    <= done_d;
         tout_q    <= tout_d;
         aborted_q <= aborted_d;
         rem_q     <= rem_d;
         cur_adr_q <= cur_adr_d;
         cmd_dat_q <= cmd_dat_d;
         tcnt_q    <= tcnt_d;
         csr_do_q  <= csr_do_d;
      end
   end

   assign csr_do   = csr_do_q;
   assign wb_adr_o = cur_adr_q;
   assign wb_dat_o = cmd_dat_q;
   assign wb_sel_o = sel_q;
   assign wb_we_o  = we_q;
   assign wb_cti_o = 3'b000;
   assign irq      = done_q | tout_q;

endmodule

// File: tb/tb_csr_wbmaster.sv
// Directed testbench for csr_wbmaster with a one-wait-state Wishbone slave model.
// Slave read data for address A is (A>>2) - 0x7F, so 0x200.. returns 1,2,3,...
// Checks are immediate assertions sampled on the falling clock edge.
module tb_csr_wbmaster;
   import csr_wbmaster_pkg::*;

   logic        sys_clk = 1'b0;
   logic        sys_rst = 1'b0;
   logic [13:0] csr_a   = 14'd0;
   logic        csr_we  = 1'b0;
   logic [31:0] csr_di  = 32'd0;
   logic [31:0] csr_do;
   logic [31:0] wb_adr_o, wb_dat_o;
   logic [31:0] wb_dat_i = 32'd0;
   logic [3:0]  wb_sel_o;
   logic [2:0]  wb_cti_o;
   logic        wb_we_o, wb_cyc_o, wb_stb_o;
   logic        wb_ack_i = 1'b0;
   logic        irq;

   int passed = 0;
   int total  = 0;
   int fails  = 0;

   csr_wbmaster dut (
      .sys_clk (sys_clk),
      .sys_rst (sys_rst),
      .csr_a   (csr_a),
      .csr_we  (csr_we),
      .csr_di  (csr_di),
      .csr_do  (csr_do),
      .wb_adr_o(wb_adr_o),
      .wb_dat_o(wb_dat_o),
      .wb_dat_i(wb_dat_i),
      .wb_sel_o(wb_sel_o),
      .wb_cti_o(wb_cti_o),
      .wb_we_o (wb_we_o),
      .wb_cyc_o(wb_cyc_o),
      .wb_stb_o(wb_stb_o),
      .wb_ack_i(wb_ack_i),
      .irq     (irq)
   );

   always #5 sys_clk = ~sys_clk;

   // Slave: acks one cycle after seeing a request, when enabled
   logic slave_en = 1'b1;
   always @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) wb_ack_i <= 1'b0;
      else         wb_ack_i <= slave_en && wb_cyc_o && wb_stb_o && !wb_ack_i;
   end
   always @(posedge sys_clk) wb_dat_i <= {2'b00, wb_adr_o[31:2]} - 32'h7F;

   // Bus monitor (cumulative counters; steps take deltas)
   int ack_cnt = 0, rise_cnt = 0, gap1_cnt = 0, stb_cyc = 0, low_run = 0;
   logic stb_prev = 1'b0;
   logic [31:0] last_adr = 32'd0, prev_adr = 32'd0, last_dat = 32'd0;
   logic last_we = 1'b0;
   always @(posedge sys_clk) begin
      if (wb_stb_o) stb_cyc++;
      if (wb_stb_o && !stb_prev) begin
         if (low_run == 1) gap1_cnt++;
         rise_cnt++;
      end
      low_run  = wb_stb_o ? 0 : low_run + 1;
      stb_prev = wb_stb_o;
      if (wb_cyc_o && wb_stb_o && wb_ack_i) begin
         ack_cnt++;
         prev_adr = last_adr;
         last_adr = wb_adr_o;
         last_dat = wb_dat_o;
         last_we  = wb_we_o;
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic csr_wr(input logic [2:0] idx, input logic [31:0] d);
      @(negedge sys_clk);
      csr_a  = {4'h9, 7'd0, idx};
      csr_di = d;
      csr_we = 1'b1;
      @(negedge sys_clk);
      csr_we = 1'b0;
   endtask

   task automatic csr_rd(input logic [2:0] idx, output logic [31:0] v);
      @(negedge sys_clk);
      csr_a  = {4'h9, 7'd0, idx};
      csr_we = 1'b0;
      @(negedge sys_clk);
      v = csr_do;
   endtask

   task automatic wait_idle(input string tag);
      logic [31:0] st;
      st = 32'd1;
      for (int i = 0; i < 200 && st[0]; i++) csr_rd(REG_STATUS, st);
      check(tag, {31'd0, st[0]}, 32'd0);
   endtask

   initial begin
      logic [31:0] v;
      int a0, r0, g0, s0, rises;
      logic prev;

      // ---- reset state ----
      #2 sys_rst = 1'b1;
      #1;
      check("rst_cyc", {31'd0, wb_cyc_o}, 32'd0);
      check("rst_stb", {31'd0, wb_stb_o}, 32'd0);
      check("rst_we",  {31'd0, wb_we_o},  32'd0);
      check("rst_sel", {28'd0, wb_sel_o}, 32'd0);
      check("rst_adr", wb_adr_o, 32'd0);
      check("rst_csr_do", csr_do, 32'd0);
      check("rst_irq", {31'd0, irq}, 32'd0);
      repeat (2) @(negedge sys_clk);
      sys_rst = 1'b0;
      csr_rd(REG_TIMEOUT, v); check("rst_timeout", v, 32'd1024);
      csr_rd(REG_STATUS, v);  check("rst_status", v, 32'd0);
      csr_rd(REG_ADDR, v);    check("rst_addr", v, 32'd0);

      // ---- single write ----
      csr_wr(REG_ADDR, 32'h0000_0100);
      csr_wr(REG_WDATA, 32'hDEAD_BEEF);
      csr_wr(REG_COUNT, 32'd1);
      a0 = ack_cnt;
      csr_wr(REG_CTRL, 32'h0000_00F3);
      check("wr_cyc_after_start", {31'd0, wb_cyc_o}, 32'd1);
      check("wr_adr", wb_adr_o, 32'h0000_0100);
      check("wr_dat", wb_dat_o, 32'hDEAD_BEEF);
      check("wr_we",  {31'd0, wb_we_o}, 32'd1);
      check("wr_sel", {28'd0, wb_sel_o}, 32'hF);
      @(negedge sys_clk);
      @(negedge sys_clk);
      check("wr_gap_cyc", {31'd0, wb_cyc_o}, 32'd0);
      check("wr_gap_irq", {31'd0, irq}, 32'd1);
      csr_rd(REG_STATUS, v); check("wr_status", v, 32'h2);
      check("wr_acks", ack_cnt - a0, 32'd1);
      check("wr_bus_adr", last_adr, 32'h0000_0100);
      check("wr_bus_dat", last_dat, 32'hDEAD_BEEF);
      check("wr_bus_we", {31'd0, last_we}, 32'd1);
      csr_rd(REG_CTRL, v); check("ctrl_readback", v, 32'h0000_00F2);
      csr_wr(REG_STATUS, 32'h2);
      check("w1c_irq", {31'd0, irq}, 32'd0);

      // ---- read burst with checksum ----
      csr_wr(REG_ADDR, 32'h0000_0200);
      csr_wr(REG_COUNT, 32'd4);
      a0 = ack_cnt; r0 = rise_cnt; g0 = gap1_cnt;
      csr_wr(REG_CTRL, 32'h0000_00F1);
      wait_idle("rd_busy_clear");
      csr_rd(REG_RDATA, v);  check("rd_rdata", v, 32'd4);
      csr_rd(REG_SUM, v);    check("rd_sum", v, 32'd10);
      check("rd_acks", ack_cnt - a0, 32'd4);
      check("rd_req_phases", rise_cnt - r0, 32'd4);
      check("rd_one_cycle_gaps", gap1_cnt - g0, 32'd3);
      csr_rd(REG_STATUS, v); check("rd_status", v, 32'h2);
      csr_rd(REG_ADDR, v);   check("rd_addr_unchanged", v, 32'h0000_0200);

      // ---- timeout ----
      csr_wr(REG_STATUS, 32'hE);
      csr_wr(REG_TIMEOUT, 32'd8);
      slave_en = 1'b0;
      csr_wr(REG_ADDR, 32'h0000_0300);
      csr_wr(REG_COUNT, 32'd1);
      a0 = ack_cnt; r0 = rise_cnt; s0 = stb_cyc;
      csr_wr(REG_CTRL, 32'h0000_00F1);
      wait_idle("to_busy_clear");
      repeat (5) @(negedge sys_clk);
      check("to_stb_cycles", stb_cyc - s0, 32'd8);
      check("to_req_phases", rise_cnt - r0, 32'd1);
      check("to_acks", ack_cnt - a0, 32'd0);
      csr_rd(REG_STATUS, v); check("to_status", v, 32'h4);
      check("to_irq", {31'd0, irq}, 32'd1);
      csr_wr(REG_STATUS, 32'h4);
      slave_en = 1'b1;

      // ---- abort during third REQ ----
      csr_wr(REG_ADDR, 32'h0000_0400);
      csr_wr(REG_COUNT, 32'd16);
      a0 = ack_cnt; r0 = rise_cnt;
      csr_wr(REG_CTRL, 32'h0000_00F1);
      rises = 0; prev = 1'b0;
      for (int i = 0; i < 200 && rises < 3; i++) begin
         @(negedge sys_clk);
         if (wb_stb_o && !prev) rises++;
         prev = wb_stb_o;
      end
      check("ab_reached_third_req", rises, 32'd3);
      csr_wr(REG_CTRL, 32'h0000_0004);
      check("ab_cyc_dropped", {31'd0, wb_cyc_o}, 32'd0);
      csr_rd(REG_STATUS, v); check("ab_status", v, 32'h8);
      check("ab_acks_le3", {31'd0, (ack_cnt - a0) <= 3}, 32'd1);
      csr_rd(REG_RDATA, v);  check("ab_rdata", v, 32'h83);
      csr_rd(REG_SUM, v);    check("ab_sum", v, 32'h186);
      repeat (4) @(negedge sys_clk);
      check("ab_no_more_req", rise_cnt - r0, 32'd3);

      // ---- COUNT = 0 ----
      csr_wr(REG_STATUS, 32'h8);
      csr_wr(REG_COUNT, 32'd0);
      r0 = rise_cnt;
      csr_wr(REG_CTRL, 32'h0000_0001);
      check("c0_no_cyc", {31'd0, wb_cyc_o}, 32'd0);
      check("c0_irq_next_cycle", {31'd0, irq}, 32'd1);
      csr_rd(REG_STATUS, v); check("c0_status", v, 32'h2);
      check("c0_req_phases", rise_cnt - r0, 32'd0);

      // ---- address wrap ----
      csr_wr(REG_STATUS, 32'h2);
      csr_wr(REG_ADDR, 32'hFFFF_FFFC);
      csr_wr(REG_WDATA, 32'h1234_5678);
      csr_wr(REG_COUNT, 32'd2);
      a0 = ack_cnt;
      csr_wr(REG_CTRL, 32'h0000_00F3);
      wait_idle("wrap_busy_clear");
      check("wrap_acks", ack_cnt - a0, 32'd2);
      check("wrap_first_adr", prev_adr, 32'hFFFF_FFFC);
      check("wrap_second_adr", last_adr, 32'h0000_0000);
      check("wrap_dat", last_dat, 32'h1234_5678);

      // ---- unselected page reads zero ----
      @(negedge sys_clk);
      csr_a = {4'h8, 7'd0, REG_ADDR};
      @(negedge sys_clk);
      check("page_unselected", csr_do, 32'd0);

      // ---- asynchronous reset mid-REQ ----
      csr_wr(REG_TIMEOUT, 32'd0);
      slave_en = 1'b0;
      csr_wr(REG_ADDR, 32'h0000_0500);
      csr_wr(REG_COUNT, 32'd1);
      csr_wr(REG_CTRL, 32'h0000_00F3);
      repeat (3) @(negedge sys_clk);
      check("ar_cyc_before", {31'd0, wb_cyc_o}, 32'd1);
      #2 sys_rst = 1'b1;
      #1;
      check("ar_cyc", {31'd0, wb_cyc_o}, 32'd0);
      check("ar_stb", {31'd0, wb_stb_o}, 32'd0);
      check("ar_adr", wb_adr_o, 32'd0);
      check("ar_sel", {28'd0, wb_sel_o}, 32'd0);
      check("ar_irq", {31'd0, irq}, 32'd0);
      @(negedge sys_clk);
      sys_rst  = 1'b0;
      slave_en = 1'b1;
      csr_rd(REG_TIMEOUT, v); check("ar_timeout", v, 32'd1024);
      csr_rd(REG_ADDR, v);    check("ar_addr", v, 32'd0);
      csr_rd(REG_COUNT, v);   check("ar_count", v, 32'd0);
      csr_rd(REG_STATUS, v);  check("ar_status", v, 32'd0);
      csr_rd(REG_SUM, v);     check("ar_sum", v, 32'd0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
